// File: rtl/seg_scan_if.sv
// ---------------------------------------------------------------------------
// seg_scan_if
// Signal bundle between a display-data producer and the seg_scan_mux scanner.
//   en         producer -> scanner  scan enable; 0 = display dark
//   digits_bcd producer -> scanner  packed BCD digits, digit i at [4i+3:4i]
//   dp_in      producer -> scanner  decimal point per digit
//   seg_out    scanner -> producer  {dp,g,f,e,d,c,b,a}
//   seg_sel    scanner -> producer  one-hot digit select (digit i -> bit N_DIGITS-1-i)
//   digit_idx  scanner -> producer  index of digit currently driven
//   scan_tick  scanner -> producer  one-cycle pulse at the start of each frame
// Modports: master = producer side, slave = scanner side.
// ---------------------------------------------------------------------------
interface seg_scan_if #(
    parameter int N_DIGITS = 6
);
    logic                    en;
    logic [4*N_DIGITS-1:0]   digits_bcd;
    logic [N_DIGITS-1:0]     dp_in;
    logic [7:0]              seg_out;
    logic [N_DIGITS-1:0]     seg_sel;
    logic [3:0]              digit_idx;
    logic                    scan_tick;

    modport master (
        output en, digits_bcd, dp_in,
        input  seg_out, seg_sel, digit_idx, scan_tick
    );

    modport slave (
        input  en, digits_bcd, dp_in,
        output seg_out, seg_sel, digit_idx, scan_tick
    );
endinterface

// File: rtl/seg_scan_mux.sv
// ---------------------------------------------------------------------------
// seg_scan_mux
// Time-multiplexed 7-segment scanner. Each frame snapshots all BCD digits and
// decimal points, then drives one digit at a time for CLK_DIV cycles with a
// BLANK_CYC-cycle all-dark gap between digits to suppress ghosting.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    seg_scan_if.slave: en, digits_bcd, dp_in in; seg_out, seg_sel,
//          digit_idx, scan_tick out (all outputs registered)
// Optional feature: define SEG_SCAN_LZB_EN to enable leading-zero blanking
// (leading zero digits without dp are dark; digit 0 is never blanked).
// ---------------------------------------------------------------------------
module seg_scan_mux #(
    parameter int N_DIGITS    = 6,
    parameter int CLK_DIV     = 50000,
    parameter int BLANK_CYC   = 16,
    parameter int SEL_ACT_LOW = 0,
    parameter int SEG_ACT_LOW = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam int CNT_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]    DRIVE_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]    BLANK_LAST = (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : {CNT_W{1'b0}};
    localparam logic [7:0]          SEG_OFF    = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [N_DIGITS-1:0] SEL_OFF    = (SEL_ACT_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    // BCD to active-high {g,f,e,d,c,b,a}; non-decimal codes show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h40;
        endcase
        return seg;
    endfunction

`ifdef SEG_SCAN_LZB_EN
    // Marks digits that sit in the leading run of zero digits with no dp,
    // scanning from the most significant digit down; digit 0 always shows.
    function automatic logic [N_DIGITS-1:0] lzb_mask(input logic [4*N_DIGITS-1:0] dig,
                                                     input logic [N_DIGITS-1:0]   dp);
        logic [N_DIGITS-1:0] mask;
        logic                run;
        mask = {N_DIGITS{1'b0}};
        run  = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            if ((dig[4*i +: 4] != 4'd0) || dp[i]) begin
                run = 1'b0;
            end else begin
                run = run;
            end
            mask[i] = run;
        end
        return mask;
    endfunction
`endif

    state_t                state_r, state_nxt_s;
    logic [3:0]            idx_r, idx_nxt_s, idx_inc_s;
    logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
    logic                  snap_take_s;
    logic [4*N_DIGITS-1:0] snap_dig_r, snap_dig_nxt_s;
    logic [N_DIGITS-1:0]   snap_dp_r, snap_dp_nxt_s;
    logic [N_DIGITS-1:0]   sel_act_s, sel_nxt_s, seg_sel_r;
    logic [7:0]            seg_act_s, seg_nxt_s, seg_out_r;
    logic [3:0]            digit_s;
    logic                  dp_s;
    logic                  tick_r;
`ifdef SEG_SCAN_LZB_EN
    logic [N_DIGITS-1:0]   mask_s;
    logic                  blank_s;
`endif

    assign idx_inc_s = (idx_r == 4'(N_DIGITS - 1)) ? 4'd0 : (idx_r + 4'd1);

    // Next-state logic: phase sequencing, digit advance and snapshot request.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        cnt_nxt_s   = cnt_r;
        snap_take_s = 1'b0;
        if (!bus.en) begin
            state_nxt_s = IDLE;
            idx_nxt_s   = 4'd0;
            cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = DRIVE;
                    idx_nxt_s   = 4'd0;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    snap_take_s = 1'b1;
                end
                DRIVE: begin
                    if (cnt_r == DRIVE_LAST) begin
                        cnt_nxt_s = {CNT_W{1'b0}};
                        if (BLANK_CYC == 0) begin
                            state_nxt_s = DRIVE;
                            idx_nxt_s   = idx_inc_s;
                            snap_take_s = (idx_inc_s == 4'd0);
                        end else begin
                            state_nxt_s = BLANK;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end
                BLANK: begin
                    if (cnt_r == BLANK_LAST) begin
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        state_nxt_s = DRIVE;
                        idx_nxt_s   = idx_inc_s;
                        snap_take_s = (idx_inc_s == 4'd0);
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    idx_nxt_s   = 4'd0;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Output decode from the next state so registered outputs line up with the state.
    // Snapshot is forwarded on capture so digit 0 shows fresh data in its first cycle.
    always_comb begin
        snap_dig_nxt_s = snap_take_s ? bus.digits_bcd : snap_dig_r;
        snap_dp_nxt_s  = snap_take_s ? bus.dp_in : snap_dp_r;
        sel_act_s      = {N_DIGITS{1'b0}};
        seg_act_s      = 8'h00;
        digit_s        = 4'd0;
        dp_s           = 1'b0;
`ifdef SEG_SCAN_LZB_EN
        mask_s         = lzb_mask(snap_dig_nxt_s, snap_dp_nxt_s);
        blank_s        = 1'b0;
`endif
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_nxt_s == 4'(i)) begin
                sel_act_s[N_DIGITS-1-i] = 1'b1;
                digit_s                 = snap_dig_nxt_s[4*i +: 4];
                dp_s                    = snap_dp_nxt_s[i];
`ifdef SEG_SCAN_LZB_EN
                blank_s                 = mask_s[i];
`endif
            end else begin
                sel_act_s[N_DIGITS-1-i] = 1'b0;
            end
        end
        if (state_nxt_s == DRIVE) begin
            seg_act_s = {dp_s, seg_decode(digit_s)};
`ifdef SEG_SCAN_LZB_EN
            if (blank_s) begin
                seg_act_s = 8'h00;
            end else begin
                seg_act_s = {dp_s, seg_decode(digit_s)};
            end
`endif
        end else begin
            sel_act_s = {N_DIGITS{1'b0}};
            seg_act_s = 8'h00;
        end
        seg_nxt_s = (SEG_ACT_LOW != 0) ? ~seg_act_s : seg_act_s;
        sel_nxt_s = (SEL_ACT_LOW != 0) ? ~sel_act_s : sel_act_s;
    end

    // State, counters, snapshot and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            idx_r      <= 4'd0;
            cnt_r      <= {CNT_W{1'b0}};
            snap_dig_r <= {(4*N_DIGITS){1'b0}};
            snap_dp_r  <= {N_DIGITS{1'b0}};
            seg_out_r  <= SEG_OFF;
            seg_sel_r  <= SEL_OFF;
            tick_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            idx_r      <= idx_nxt_s;
            cnt_r      <= cnt_nxt_s;
            snap_dig_r <= snap_dig_nxt_s;
            snap_dp_r  <= snap_dp_nxt_s;
            seg_out_r  <= seg_nxt_s;
            seg_sel_r  <= sel_nxt_s;
            tick_r     <= snap_take_s;
        end
    end

    assign bus.seg_out   = seg_out_r;
    assign bus.seg_sel   = seg_sel_r;
    assign bus.digit_idx = idx_r;
    assign bus.scan_tick = tick_r;

endmodule

// File: tb/tb_seg_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_mux
// Bench for seg_scan_mux with N_DIGITS=4, CLK_DIV=4, BLANK_CYC=2, active-high
// polarities. Expected per-cycle output words are queued when a frame's data
// is applied and popped/compared on each falling edge.
// ---------------------------------------------------------------------------
module tb_seg_scan_mux;
    localparam int N  = 4;
    localparam int CD = 4;
    localparam int BC = 2;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] seg;
        logic [3:0] idx;
        logic       tick;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    seg_scan_if #(.N_DIGITS(N)) bus ();

    seg_scan_mux #(
        .N_DIGITS   (N),
        .CLK_DIV    (CD),
        .BLANK_CYC  (BC),
        .SEL_ACT_LOW(0),
        .SEG_ACT_LOW(0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    function automatic logic [6:0] bcd7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0: s = 7'h3F; 4'd1: s = 7'h06; 4'd2: s = 7'h5B; 4'd3: s = 7'h4F;
            4'd4: s = 7'h66; 4'd5: s = 7'h6D; 4'd6: s = 7'h7D; 4'd7: s = 7'h07;
            4'd8: s = 7'h7F; 4'd9: s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // Queue one frame of expected per-cycle outputs for the given snapshot.
    task automatic push_frame(input logic [15:0] dig, input logic [3:0] dp);
        logic [3:0] lz;
        logic       run;
        logic [3:0] nib;
        logic [7:0] seg;
        exp_t       e;
        lz  = 4'b0000;
        run = 1'b1;
        for (int d = N - 1; d >= 1; d--) begin
            nib = dig[4*d +: 4];
            if (nib != 4'd0 || dp[d]) run = 1'b0;
            lz[d] = run;
        end
`ifndef SEG_SCAN_LZB_EN
        lz = 4'b0000;
`endif
        for (int d = 0; d < N; d++) begin
            nib = dig[4*d +: 4];
            seg = lz[d] ? 8'h00 : {dp[d], bcd7(nib)};
            for (int c = 0; c < CD; c++) begin
                e.sel  = 4'b1000 >> d;
                e.seg  = seg;
                e.idx  = 4'(d);
                e.tick = (d == 0 && c == 0);
                exp_q.push_back(e);
            end
            for (int c = 0; c < BC; c++) begin
                e.sel  = 4'b0000;
                e.seg  = 8'h00;
                e.idx  = 4'(d);
                e.tick = 1'b0;
                exp_q.push_back(e);
            end
        end
    endtask

    // Drop enable for a cycle, then re-enable with new data (scan restarts at digit 0).
    task automatic restart(input logic [15:0] dig, input logic [3:0] dp);
        @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        bus.en         = 1'b1;
        bus.digits_bcd = dig;
        bus.dp_in      = dp;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.seg_sel, bus.seg_out, bus.digit_idx, bus.scan_tick} !== 17'd0) begin
            tests_failed++;
            $display("FAIL reset_init: got sel=%b seg=%h idx=%0d tick=%b, want all 0",
                     bus.seg_sel, bus.seg_out, bus.digit_idx, bus.scan_tick);
        end
        @(negedge clk);
        rst_n          = 1'b1;
        bus.en         = 1'b1;
        bus.digits_bcd = 16'h4321;
        bus.dp_in      = 4'b0000;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.seg_sel, bus.seg_out, bus.digit_idx, bus.scan_tick} !== 17'd0) begin
            tests_failed++;
            $display("FAIL reset_midscan: got sel=%b seg=%h idx=%0d tick=%b, want all 0",
                     bus.seg_sel, bus.seg_out, bus.digit_idx, bus.scan_tick);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        bus.en = 1'b0;
    endtask

    task automatic test_basic_scan();
        exp_t e;
        int   k;
        restart(16'h4321, 4'b0000);
        push_frame(16'h4321, 4'b0000);
        push_frame(16'h4321, 4'b0000);
        k = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if ({bus.seg_sel, bus.seg_out, bus.digit_idx, bus.scan_tick} !== e) begin
                tests_failed++;
                $display("FAIL basic_scan cyc%0d: got sel=%b seg=%h idx=%0d tick=%b, want sel=%b seg=%h idx=%0d tick=%b",
                         k, bus.seg_sel, bus.seg_out, bus.digit_idx, bus.scan_tick, e.sel, e.seg, e.idx, e.tick);
            end
            k++;
        end
    endtask

    task automatic test_snapshot();
        exp_t e;
        int   k;
        restart(16'h4321, 4'b0000);
        push_frame(16'h4321, 4'b0000);
        push_frame(16'h9999, 4'b0000);
        k = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if ({bus.seg_sel, bus.seg_out, bus.digit_idx, bus.scan_tick} !== e) begin
                tests_failed++;
                $display("FAIL snapshot cyc%0d: got sel=%b seg=%h idx=%0d tick=%b, want sel=%b seg=%h idx=%0d tick=%b",
                         k, bus.seg_sel, bus.seg_out, bus.digit_idx, bus.scan_tick, e.sel, e.seg, e.idx, e.tick);
            end
            k++;
            if (k == 7) bus.digits_bcd = 16'h9999;
        end
    endtask

    task automatic test_disable();
        exp_t e;
        int   k;
        restart(16'h4321, 4'b0000);
        push_frame(16'h4321, 4'b0000);
        for (k = 0; k < 13; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if ({bus.seg_sel, bus.seg_out, bus.digit_idx, bus.scan_tick} !== e) begin
                tests_failed++;
                $display("FAIL disable_pre cyc%0d: got sel=%b seg=%h idx=%0d tick=%b, want sel=%b seg=%h idx=%0d tick=%b",
                         k, bus.seg_sel, bus.seg_out, bus.digit_idx, bus.scan_tick, e.sel, e.seg, e.idx, e.tick);
            end
        end
        bus.en = 1'b0;
        exp_q.delete();
        @(negedge clk);
        tests_run++;
        if ({bus.seg_sel, bus.seg_out, bus.digit_idx, bus.scan_tick} !== 17'd0) begin
            tests_failed++;
            $display("FAIL disable_dark: got sel=%b seg=%h idx=%0d tick=%b, want all 0",
                     bus.seg_sel, bus.seg_out, bus.digit_idx, bus.scan_tick);
        end
        bus.en = 1'b1;
        push_frame(16'h4321, 4'b0000);
        k = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if ({bus.seg_sel, bus.seg_out, bus.digit_idx, bus.scan_tick} !== e) begin
                tests_failed++;
                $display("FAIL disable_restart cyc%0d: got sel=%b seg=%h idx=%0d tick=%b, want sel=%b seg=%h idx=%0d tick=%b",
                         k, bus.seg_sel, bus.seg_out, bus.digit_idx, bus.scan_tick, e.sel, e.seg, e.idx, e.tick);
            end
            k++;
        end
    endtask

    task automatic test_dp_dash();
        exp_t e;
        int   k;
        restart(16'h00B0, 4'b0010);
        push_frame(16'h00B0, 4'b0010);
        k = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if ({bus.seg_sel, bus.seg_out, bus.digit_idx, bus.scan_tick} !== e) begin
                tests_failed++;
                $display("FAIL dp_dash cyc%0d: got sel=%b seg=%h idx=%0d tick=%b, want sel=%b seg=%h idx=%0d tick=%b",
                         k, bus.seg_sel, bus.seg_out, bus.digit_idx, bus.scan_tick, e.sel, e.seg, e.idx, e.tick);
            end
            k++;
        end
    endtask

    task automatic test_leading_zero();
        exp_t e;
        int   k;
        restart(16'h0005, 4'b0000);
        push_frame(16'h0005, 4'b0000);
        k = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if ({bus.seg_sel, bus.seg_out, bus.digit_idx, bus.scan_tick} !== e) begin
                tests_failed++;
                $display("FAIL lzb_0005 cyc%0d: got sel=%b seg=%h idx=%0d tick=%b, want sel=%b seg=%h idx=%0d tick=%b",
                         k, bus.seg_sel, bus.seg_out, bus.digit_idx, bus.scan_tick, e.sel, e.seg, e.idx, e.tick);
            end
            k++;
        end
        restart(16'h0000, 4'b0000);
        push_frame(16'h0000, 4'b0000);
        k = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if ({bus.seg_sel, bus.seg_out, bus.digit_idx, bus.scan_tick} !== e) begin
                tests_failed++;
                $display("FAIL lzb_0000 cyc%0d: got sel=%b seg=%h idx=%0d tick=%b, want sel=%b seg=%h idx=%0d tick=%b",
                         k, bus.seg_sel, bus.seg_out, bus.digit_idx, bus.scan_tick, e.sel, e.seg, e.idx, e.tick);
            end
            k++;
        end
    endtask

    initial begin
        bus.en         = 1'b0;
        bus.digits_bcd = 16'h0000;
        bus.dp_in      = 4'b0000;
        test_reset();
        test_basic_scan();
        test_snapshot();
        test_disable();
        test_dp_dash();
        test_leading_zero();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
